// File: rtl/health_pkg.sv
// Shared definitions for the health sensor round scheduler: FSM encoding,
// channel numbering and operand field positions within the 8-bit bus word.
package health_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StGap,
      StEval,
      StCapt
   } schedState_e;

   localparam int unsigned NUM_CH = 5;

   localparam logic [2:0] CH_PRESSURE = 3'd0;
   localparam logic [2:0] CH_BLOOD    = 3'd1;
   localparam logic [2:0] CH_FALL     = 3'd2;
   localparam logic [2:0] CH_GLUCOSE  = 3'd3;
   localparam logic [2:0] CH_TEMP     = 3'd4;

   localparam int unsigned PERSIST_W = 4;

   localparam int unsigned PRESSURE_HI = 5;
   localparam int unsigned PRESSURE_LO = 0;
   localparam int unsigned PH_HI       = 6;
   localparam int unsigned PH_LO       = 3;
   localparam int unsigned TYPE_HI     = 2;
   localparam int unsigned TYPE_LO     = 0;
   localparam int unsigned TEMP_HI     = 3;
   localparam int unsigned TEMP_LO     = 0;

   function automatic logic isLastChannel(logic [2:0] ch);
      return ch == 3'(NUM_CH - 1);
   endfunction

endpackage

// File: rtl/abnormality_persist.sv
// Persistence filter: an alarm rises only after PERSIST consecutive abnormal
// captures and drops on the first normal one.
module abnormality_persist
   import health_pkg::*;
#(
   parameter int unsigned PERSIST = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic update,
   input  logic flag,
   output logic alarm
);

   localparam logic [PERSIST_W-1:0] Limit = PERSIST_W'(PERSIST);

   logic [PERSIST_W-1:0] cntQ, cntD;

   always_comb begin
      cntD = cntQ;
      if (update) begin
         if (!flag) begin
            cntD = '0;
         end else if (cntQ != Limit) begin
            cntD = cntQ + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cntQ <= '0;
      end else begin
         cntQ <= cntD;
      end
   end

   assign alarm = (cntQ == Limit);

endmodule

// File: rtl/health_sensor_scheduler.sv
// Polls the five sensor channels each round, holds the detector operands for one
// evaluation cycle, then captures and filters the detector results.
module health_sensor_scheduler
   import health_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD = 16,
   parameter int unsigned ACK_TIMEOUT   = 8,
   parameter int unsigned PERSIST       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clearFall,
   output logic       sensorReq,
   output logic [2:0] sensorSel,
   input  logic       sensorAck,
   input  logic [7:0] sensorData,
   output logic [5:0] pressureData,
   output logic [3:0] bloodPH,
   output logic [2:0] bloodType,
   output logic [7:0] fdSensorValue,
   output logic [7:0] bloodSensor,
   output logic [3:0] tempSensorValue,
   input  logic       presureAbnormality,
   input  logic       bloodAbnormality,
   input  logic       fallDetected,
   input  logic       temperatureAbnormality,
   input  logic [3:0] glycemicIndex,
   output logic       pressureAlarm,
   output logic       bloodAlarm,
   output logic       tempAlarm,
   output logic       fallAlarm,
   output logic [3:0] glycemicOut,
   output logic       resultValid,
   output logic       sensorFault,
   output logic [2:0] faultChannel
);

   localparam int unsigned PeriodW  = $clog2(SAMPLE_PERIOD);
   localparam int unsigned TimeoutW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [PeriodW-1:0]  PeriodReload = PeriodW'(SAMPLE_PERIOD - 1);
   localparam logic [TimeoutW-1:0] WaitLast     = TimeoutW'(ACK_TIMEOUT - 1);

   schedState_e          stateQ, stateD;
   logic [2:0]           chQ, chD;
   logic [PeriodW-1:0]   periodQ, periodD;
   logic [TimeoutW-1:0]  waitQ, waitD;
   logic                 ackTake, timedOut, chDone, captEdge;

   // An ack in the final wait cycle still wins over the timeout.
   assign ackTake  = (stateQ == StReq) && sensorAck;
   assign timedOut = (stateQ == StReq) && !sensorAck && (waitQ == WaitLast);
   assign chDone   = ackTake || timedOut;
   assign captEdge = (stateQ == StEval);

   always_comb begin
      stateD      = stateQ;
      chD         = chQ;
      waitD       = waitQ;
      periodD     = (periodQ != '0) ? periodQ - 1'b1 : '0;
      sensorReq   = 1'b0;
      sensorSel   = '0;
      resultValid = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if ((periodQ == '0) && enable) begin
               stateD  = StReq;
               chD     = CH_PRESSURE;
               waitD   = '0;
               periodD = PeriodReload;
            end
         end
         StReq: begin
            sensorReq = 1'b1;
            sensorSel = chQ;
            waitD     = waitQ + 1'b1;
            if (chDone) begin
               waitD  = '0;
               stateD = isLastChannel(chQ) ? StEval : StGap;
            end
         end
         StGap: begin
            chD    = chQ + 3'd1;
            stateD = StReq;
         end
         StEval: begin
            stateD = StCapt;
         end
         StCapt: begin
            resultValid = 1'b1;
            stateD      = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ  <= StIdle;
         chQ     <= CH_PRESSURE;
         periodQ <= '0;
         waitQ   <= '0;
      end else begin
         stateQ  <= stateD;
         chQ     <= chD;
         periodQ <= periodD;
         waitQ   <= waitD;
      end
   end

   // Operands move only on an accepted ack, so they are stable through EVAL.
   always_ff @(posedge clk) begin
      if (rst) begin
         pressureData    <= '0;
         bloodPH         <= '0;
         bloodType       <= '0;
         fdSensorValue   <= '0;
         bloodSensor     <= '0;
         tempSensorValue <= '0;
      end else if (ackTake) begin
         case (chQ)
            CH_PRESSURE: pressureData <= sensorData[PRESSURE_HI:PRESSURE_LO];
            CH_BLOOD: begin
               bloodPH   <= sensorData[PH_HI:PH_LO];
               bloodType <= sensorData[TYPE_HI:TYPE_LO];
            end
            CH_FALL:    fdSensorValue   <= sensorData;
            CH_GLUCOSE: bloodSensor     <= sensorData;
            CH_TEMP:    tempSensorValue <= sensorData[TEMP_HI:TEMP_LO];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         glycemicOut  <= '0;
         fallAlarm    <= 1'b0;
         sensorFault  <= 1'b0;
         faultChannel <= '0;
      end else begin
         if (captEdge) begin
            glycemicOut <= glycemicIndex;
         end
         if (captEdge && fallDetected) begin
            fallAlarm <= 1'b1;
         end else if (clearFall) begin
            fallAlarm <= 1'b0;
         end
         if (timedOut) begin
            sensorFault  <= 1'b1;
            faultChannel <= chQ;
         end
      end
   end

   abnormality_persist #(.PERSIST(PERSIST)) uPressure (
      .clk    (clk),
      .rst    (rst),
      .update (captEdge),
      .flag   (presureAbnormality),
      .alarm  (pressureAlarm)
   );

   abnormality_persist #(.PERSIST(PERSIST)) uBlood (
      .clk    (clk),
      .rst    (rst),
      .update (captEdge),
      .flag   (bloodAbnormality),
      .alarm  (bloodAlarm)
   );

   abnormality_persist #(.PERSIST(PERSIST)) uTemp (
      .clk    (clk),
      .rst    (rst),
      .update (captEdge),
      .flag   (temperatureAbnormality),
      .alarm  (tempAlarm)
   );

endmodule
